// File: rtl/logic_unit_arbiter.sv
// Two-requester bitwise logic unit (AND/OR/XOR/NOR) with round-robin
// tie-break, fixed 2-cycle latency and a valid/ready response port.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  state_t           state;
  state_t           state_nx;
  logic             prio;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] result;

  // Grant: a lone requester wins; on a tie the one matching prio wins.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || !prio);
    gnt1 = req1_valid && (!req0_valid ||  prio);
  end

  // Ready only while idle and never while reset is held.
  assign req0_ready = (state == IDLE) && !rst && gnt0;
  assign req1_ready = (state == IDLE) && !rst && gnt1;
  assign accept     = req0_ready || req1_ready;

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bitwise result of the latched operation, no width growth.
  always_comb begin
    result = '0;
    unique case (op_q)
      OP_AND: result = a_q & b_q;
      OP_OR:  result = a_q | b_q;
      OP_XOR: result = a_q ^ b_q;
      OP_NOR: result = ~(a_q | b_q);
      default: result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture on accept; prio flips away from the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
    end else if (accept) begin
      prio <= ~gnt1;
      id_q <= gnt1;
      op_q <= gnt1 ? req1_op : req0_op;
      a_q  <= gnt1 ? req1_a  : req0_a;
      b_q  <= gnt1 ? req1_b  : req0_b;
    end
  end

  // Response registers, loaded only in EXEC and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data <= '0;
      resp_zero <= 1'b1;
      resp_id   <= 1'b0;
    end else if (state == EXEC) begin
      resp_data <= result;
      resp_zero <= ~|result;
      resp_id   <= id_q;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: expected responses are
// queued at accept time and compared when resp_valid is seen.
module tb_logic_unit_arbiter;

  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_id, resp_zero, busy;
  logic [W-1:0] resp_data;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .resp_zero(resp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(logic [1:0] op,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    resp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_chk++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_ready got %b exp 00", {req1_ready, req0_ready});
      end
      n_chk++;
      if ({resp_valid, busy, resp_zero} !== 3'b001 || resp_data !== '0) begin
        n_fail++;
        $display("FAIL reset_state got v%b b%b z%b d%h exp v0 b0 z1 d0",
                 resp_valid, busy, resp_zero, resp_data);
      end
    end
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b00;
    req0_a = 32'h3B9ACA07; req0_b = 32'h0000008F;
    resp_ready = 1'b1;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept got %b exp 1", req0_ready);
    end else q.push_back('{id: 1'b0, data: 32'h00000007});
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if (resp_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_exec got v%b b%b exp v0 b1", resp_valid, busy);
    end
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL single_latency got v%b q%0d exp v1", resp_valid, q.size());
    end else begin
      e = q.pop_front();
      if ({resp_id, resp_data} !== {e.id, e.data} ||
          resp_zero !== (e.data == '0)) begin
        n_fail++;
        $display("FAIL single_resp got id%b d%h z%b exp id%b d%h",
                 resp_id, resp_data, resp_zero, e.id, e.data);
      end
    end
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'h7) begin
      n_fail++;
      $display("FAIL single_hold got v%b b%b d%h exp v0 b0 d7",
               resp_valid, busy, resp_data);
    end
  endtask

  task automatic test_arbitration;
    exp_t e;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01;
    req0_a = 32'h000F4335; req0_b = 32'h00020D16;
    req1_valid = 1'b1; req1_op = 2'b10;
    req1_a = 32'hFFFF0000; req1_b = 32'h00FF00FF;
    #1;
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL arb_tie got %b exp 01", {req1_ready, req0_ready});
    end else q.push_back('{id: 1'b0, data: 32'h000F4F37});
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL arb_first_valid got v%b exp 1", resp_valid);
    end else begin
      e = q.pop_front();
      if ({resp_id, resp_data} !== {e.id, e.data} || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL arb_first got id%b d%h r1%b exp id%b d%h r1 0",
                 resp_id, resp_data, req1_ready, e.id, e.data);
      end
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_second_accept got %b exp 1", req1_ready);
    end else q.push_back('{id: 1'b1, data: 32'hFF0000FF});
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL arb_second_valid got v%b exp 1", resp_valid);
    end else begin
      e = q.pop_front();
      if ({resp_id, resp_data, resp_zero} !== {e.id, e.data, 1'b0}) begin
        n_fail++;
        $display("FAIL arb_second got id%b d%h z%b exp id%b d%h z0",
                 resp_id, resp_data, resp_zero, e.id, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    exp_t         e;
    logic [W-1:0] hd;
    logic         hi;
    logic         bad;
    @(negedge clk);
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b10;
    req0_a = 32'h12345678; req0_b = 32'h0F0F0F0F;
    #1;
    n_chk++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept got %b exp 1", req0_ready);
    end else q.push_back('{id: 1'b0, data: model(2'b10, req0_a, req0_b)});
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b11;
    req1_a = 32'h00FF0000; req1_b = 32'h000000F0;
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL bp_valid got v%b exp 1", resp_valid);
    end else begin
      e = q.pop_front();
      if ({resp_id, resp_data} !== {e.id, e.data}) begin
        n_fail++;
        $display("FAIL bp_resp got id%b d%h exp id%b d%h",
                 resp_id, resp_data, e.id, e.data);
      end
    end
    hd = resp_data; hi = resp_id; bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== hd || resp_id !== hi ||
          req1_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold got v%b d%h id%b r1%b b%b exp v1 d%h id%b r1 0 b1",
               resp_valid, resp_data, resp_id, req1_ready, busy, hd, hi);
    end
    resp_ready = 1'b1;
    #1;
    n_chk++;
    if (req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_early_accept got %b exp 0", req1_ready);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next_accept got %b exp 1", req1_ready);
    end else q.push_back('{id: 1'b1, data: model(2'b11, req1_a, req1_b)});
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL bp_second_valid got v%b exp 1", resp_valid);
    end else begin
      e = q.pop_front();
      if ({resp_id, resp_data} !== {e.id, e.data}) begin
        n_fail++;
        $display("FAIL bp_second got id%b d%h exp id%b d%h",
                 resp_id, resp_data, e.id, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    exp_t e;
    logic seen;
    @(negedge clk);
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b01;
    req0_a = 32'h1; req0_b = 32'h2;
    @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({busy, resp_valid, resp_zero} !== 3'b001 || resp_data !== '0) begin
      n_fail++;
      $display("FAIL midrst_state got b%b v%b z%b d%h exp b0 v0 z1 d0",
               busy, resp_valid, resp_zero, resp_data);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrst_ghost got resp_valid 1 exp 0");
    end
    req0_valid = 1'b1; req0_op = 2'b00;
    req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
    req1_valid = 1'b1; req1_op = 2'b01;
    req1_a = 32'h1; req1_b = 32'h2;
    #1;
    n_chk++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL midrst_prio got %b exp 01", {req1_ready, req0_ready});
    end else q.push_back('{id: 1'b0, data: 32'hF000F000});
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (resp_valid !== 1'b1 || q.size() == 0) begin
      n_fail++;
      $display("FAIL midrst_valid got v%b exp 1", resp_valid);
    end else begin
      e = q.pop_front();
      if ({resp_id, resp_data} !== {e.id, e.data}) begin
        n_fail++;
        $display("FAIL midrst_resp got id%b d%h exp id%b d%h",
                 resp_id, resp_data, e.id, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_opcodes;
    logic [1:0]   ops[2] = '{2'b11, 2'b00};
    logic [W-1:0] av[2]  = '{32'h00000000, 32'hAAAAAAAA};
    logic [W-1:0] bv[2]  = '{32'h00000000, 32'h55555555};
    logic [W-1:0] dv[2]  = '{32'hFFFFFFFF, 32'h00000000};
    logic         zv[2]  = '{1'b0, 1'b1};
    exp_t e;
    resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req1_valid = 1'b1; req1_op = ops[i];
      req1_a = av[i]; req1_b = bv[i];
      #1;
      n_chk++;
      if (req1_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL op%0d_accept got %b exp 1", i, req1_ready);
      end else q.push_back('{id: 1'b1, data: dv[i]});
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (resp_valid !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL op%0d_valid got v%b exp 1", i, resp_valid);
      end else begin
        e = q.pop_front();
        if ({resp_id, resp_data, resp_zero} !== {e.id, e.data, zv[i]}) begin
          n_fail++;
          $display("FAIL op%0d_resp got id%b d%h z%b exp id%b d%h z%b",
                   i, resp_id, resp_data, resp_zero, e.id, e.data, zv[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   r;
    int   k;
    logic rdy;
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 1);
      resp_ready = 1'($urandom_range(0, 1));
      if (r == 0) begin
        req0_valid = 1'b1; req0_op = 2'($urandom_range(0, 3));
        req0_a = $urandom; req0_b = $urandom;
      end else begin
        req1_valid = 1'b1; req1_op = 2'($urandom_range(0, 3));
        req1_a = $urandom; req1_b = $urandom;
      end
      #1;
      k = 0;
      rdy = (r == 0) ? req0_ready : req1_ready;
      while (!rdy && k < 10) begin
        @(negedge clk); #1;
        rdy = (r == 0) ? req0_ready : req1_ready;
        k++;
      end
      n_chk++;
      if (!rdy) begin
        n_fail++;
        $display("FAIL b2b%0d_accept timeout got 0 exp 1", n);
      end else if (r == 0) q.push_back('{id: 1'b0, data: model(req0_op, req0_a, req0_b)});
      else q.push_back('{id: 1'b1, data: model(req1_op, req1_a, req1_b)});
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      k = 0;
      while (resp_valid !== 1'b1 && k < 10) begin
        @(negedge clk);
        k++;
      end
      n_chk++;
      if (resp_valid !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b%0d_resp timeout got v%b exp 1", n, resp_valid);
      end else begin
        e = q.pop_front();
        if ({resp_id, resp_data, resp_zero} !== {e.id, e.data, e.data == '0}) begin
          n_fail++;
          $display("FAIL b2b%0d_resp got id%b d%h z%b exp id%b d%h",
                   n, resp_id, resp_data, resp_zero, e.id, e.data);
        end
      end
      resp_ready = 1'b1;
      k = 0;
      while (resp_valid === 1'b1 && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_mid_reset();
    test_opcodes();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 bit: requester k presents an operation.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 bit: requester k's operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_op / req1_op, input, 2 bits: opcode, where 00 = AND, 01 = OR, 10 = XOR and 11 = NOR.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH bits: operands.
REQ-008 The block SHALL have port resp_valid, output, 1 bit: a result is available.
REQ-009 The block SHALL have port resp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port resp_id, output, 1 bit: index of the requester that owns the result.
REQ-011 The block SHALL have port resp_data, output, WIDTH bits: the registered result.
REQ-012 The block SHALL have port resp_zero, output, 1 bit: high when resp_data is all zeros.
REQ-013 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-014 The block SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-015 In IDLE with any reqk_valid high, the block SHALL grant one requester: a lone valid requester wins; with both valid, the requester equal to the priority bit prio wins.
REQ-016 reqk_ready SHALL be high only in IDLE and only for the granted requester; it is combinational from valid, state and prio.
REQ-017 On the accept edge (valid and ready both high), the block SHALL latch op, a, b and id, go to EXEC, and set prio to the inverse of the granted id.
REQ-018 In EXEC, the block SHALL compute the bitwise result of the latched op on the full WIDTH bits, register it into resp_data and resp_zero, and go to RESP; there is no carry or width growth.
REQ-019 In RESP, resp_valid SHALL be high, and resp_data, resp_id and resp_zero SHALL stay constant until resp_ready is sampled high.
REQ-020 On the response handshake edge, the block SHALL return to IDLE; resp_valid falls, and resp_data and resp_id keep their values until the next EXEC.
REQ-021 Latency SHALL be fixed: resp_valid rises exactly 2 cycles after the accept edge; minimum issue interval is 3 cycles.
REQ-022 A request SHALL NOT be accepted while the state is EXEC or RESP; requesters hold valid and operands until ready.
REQ-023 If resp_ready is already high when RESP is entered, the handshake SHALL complete in that first RESP cycle.
REQ-024 Requests arriving in the cycle of the RESP handshake SHALL NOT be accepted before the following IDLE cycle.
REQ-025 A requester deasserting valid before ready SHALL cause no state change.

Reset
REQ-026 While rst is high on a clock edge, the block SHALL set: state = IDLE, prio = 0, resp_valid = 0, resp_id = 0, resp_data = 0, resp_zero = 1, busy = 0.
REQ-027 Both reqk_ready outputs SHALL be low during any cycle in which rst is high.
REQ-028 A reset asserted in EXEC or RESP SHALL discard the in-flight operation, and no response for it SHALL ever appear.

Verification
REQ-029 Reset check: rst = 1 for 2 cycles with both valids high -> both readys 0, resp_valid = 0, resp_data = 0x00000000, resp_zero = 1, busy = 0.
REQ-030 Single request: req0 AND, a = 0x3B9ACA07, b = 0x0000008F, resp_ready = 1 -> accepted in the first IDLE cycle; 2 cycles later resp_valid = 1, resp_id = 0, resp_data = 0x00000007, resp_zero = 0.
REQ-031 Arbitration: both valid after reset; req0 OR, 0x000F4335 | 0x00020D16; req1 XOR, 0xFFFF0000 ^ 0x00FF00FF -> req0 served first with 0x000F4F37; req1 accepted in the next IDLE cycle with 0xFF0000FF.
REQ-032 Backpressure: resp_ready = 0 for 5 cycles in RESP, with req1 valid -> resp_valid, resp_data and resp_id stable; req1_ready stays 0; busy = 1; after resp_ready = 1, req1 is accepted one cycle later.
REQ-033 Mid-operation reset: rst pulsed in the EXEC cycle -> next cycle state = IDLE, resp_valid never rises for that request, and prio = 0, so req0 wins a following tie.
REQ-034 Opcode edges: NOR of 0x00000000 and 0x00000000 -> 0xFFFFFFFF with resp_zero = 0; AND of 0xAAAAAAAA and 0x55555555 -> 0x00000000 with resp_zero = 1.
